// File: rtl/i2c_apb_mst_pkg.sv
// Shared types and constants for the byte-stream to APB bridge.
// States, command codes, status bit layout and response lengths.
package i2c_apb_mst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WDATA  = 3'd2,
        ST_SETUP  = 3'd3,
        ST_ACCESS = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    localparam logic [7:0] CMD_RD = 8'h00;
    localparam logic [7:0] CMD_WR = 8'h01;

    localparam int STAT_ERR_BIT = 0;
    localparam int STAT_TMO_BIT = 1;

    localparam logic [2:0] RESP_LEN_WR = 3'd1;
    localparam logic [2:0] RESP_LEN_RD = 3'd5;

    function automatic logic [7:0] status_byte(input logic tmo, input logic err);
        logic [7:0] s;
        s               = '0;
        s[STAT_TMO_BIT] = tmo;
        s[STAT_ERR_BIT] = err;
        return s;
    endfunction

endpackage

// File: rtl/i2c_apb_mst.sv
// Byte-framed request stream in, APB completer access out, status/rdata bytes back.
// One APB transfer at a time; a hung completer is abandoned after TIMEOUT_CYC waits.
module i2c_apb_mst
    import i2c_apb_mst_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 256,
    parameter logic [15:0] ADDR_HI     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_start,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        apb_sel,
    output logic        apb_en,
    output logic        apb_write,
    output logic [31:0] apb_addr,
    output logic [31:0] apb_wdata,
    input  logic        apb_ready,
    input  logic [31:0] apb_rdata,
    input  logic        apb_slverr,
    output state_t      dbg_state
);

    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        r_state;
    logic [2:0]    r_cnt;
    logic [TW-1:0] r_tmo;
    logic          r_write;
    logic [15:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_slverr;
    logic          r_timeout;
    logic          r_sel;
    logic          r_en;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [7:0]    r_out_data;

    logic w_in_acc;
    logic w_out_acc;
    logic w_cmd_ok;
    logic w_resp_last;

    // Both streams transfer a byte on a cycle where valid & ready are high;
    // valid, once raised, holds with stable data until that cycle.
    assign w_in_acc    = in_valid & r_in_ready;
    assign w_out_acc   = r_out_valid & out_ready;
    assign w_cmd_ok    = (in_data == CMD_RD) || (in_data == CMD_WR);
    assign w_resp_last = (r_cnt == ((r_write ? RESP_LEN_WR : RESP_LEN_RD) - 3'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_slverr    <= 1'b0;
            r_timeout   <= 1'b0;
            r_sel       <= 1'b0;
            r_en        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ADDR, ST_WDATA: begin
                    if (w_in_acc) begin
                        // A start byte always restarts framing, even mid-frame.
                        if (in_start) begin
                            r_cnt <= '0;
                            if (w_cmd_ok) begin
                                r_write <= (in_data == CMD_WR);
                                r_state <= ST_ADDR;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else if (r_state == ST_ADDR) begin
                            if (r_cnt == 3'd0) begin
                                r_addr[15:8] <= in_data;
                                r_cnt        <= 3'd1;
                            end else begin
                                r_addr[7:0] <= in_data;
                                r_cnt       <= '0;
                                if (r_write) begin
                                    r_state <= ST_WDATA;
                                end else begin
                                    r_state    <= ST_SETUP;
                                    r_sel      <= 1'b1;
                                    r_in_ready <= 1'b0;
                                end
                            end
                        end else if (r_state == ST_WDATA) begin
                            r_wdata <= {r_wdata[23:0], in_data};
                            r_cnt   <= r_cnt + 3'd1;
                            if (r_cnt == 3'd3) begin
                                r_cnt      <= '0;
                                r_state    <= ST_SETUP;
                                r_sel      <= 1'b1;
                                r_in_ready <= 1'b0;
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    r_en    <= 1'b1;
                    r_tmo   <= '0;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A ready on the final allowed cycle completes normally.
                    if (apb_ready) begin
                        r_rdata     <= r_write ? 32'h0 : apb_rdata;
                        r_slverr    <= apb_slverr;
                        r_timeout   <= 1'b0;
                        r_out_data  <= status_byte(1'b0, apb_slverr);
                        r_sel       <= 1'b0;
                        r_en        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_RESP;
                    end else if (r_tmo == TMO_LAST) begin
                        r_rdata     <= 32'h0;
                        r_slverr    <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_out_data  <= status_byte(1'b1, 1'b0);
                        r_sel       <= 1'b0;
                        r_en        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_out_acc) begin
                        if (w_resp_last) begin
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            // rdata is consumed MSB first by shifting the capture.
                            r_out_data <= r_rdata[31:24];
                            r_rdata    <= {r_rdata[23:0], 8'h00};
                            r_cnt      <= r_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_sel      <= 1'b0;
                    r_en       <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign apb_sel   = r_sel;
    assign apb_en    = r_en;
    assign apb_write = r_write;
    assign apb_addr  = {ADDR_HI, r_addr};
    assign apb_wdata = r_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_apb_mst.sv
// Directed bench for i2c_apb_mst: framed requests in, APB completer model, response scoreboard.
module tb_i2c_apb_mst;
    import i2c_apb_mst_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_start;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        apb_sel;
    logic        apb_en;
    logic        apb_write;
    logic [31:0] apb_addr;
    logic [31:0] apb_wdata;
    logic        apb_ready;
    logic [31:0] apb_rdata;
    logic        apb_slverr;
    state_t      dbg_state;

    int errors = 0;
    int checks = 0;

    // completer model controls and monitor records
    int          wait_n   = 0;
    bit          hang     = 0;
    int          n_xfer   = 0;
    int          acc_cnt  = 0;
    int          setup_len = 0;
    int          prot_err = 0;
    bit          prev_setup  = 0;
    bit          prev_access = 0;
    logic [31:0] mon_addr  = '0;
    logic [31:0] mon_wdata = '0;
    logic        mon_write = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    i2c_apb_mst #(.TIMEOUT_CYC(8), .ADDR_HI(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_start(in_start), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .apb_sel(apb_sel), .apb_en(apb_en), .apb_write(apb_write),
        .apb_addr(apb_addr), .apb_wdata(apb_wdata),
        .apb_ready(apb_ready), .apb_rdata(apb_rdata), .apb_slverr(apb_slverr),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (apb_sel && !apb_en) begin
            setup_len = prev_setup ? setup_len + 1 : 1;
            if (!prev_setup) n_xfer++;
            mon_addr  = apb_addr;
            mon_wdata = apb_wdata;
            mon_write = apb_write;
            acc_cnt   = 0;
        end
        if (apb_en) begin
            if (!apb_sel || !(prev_setup || prev_access)) prot_err++;
            if (apb_addr !== mon_addr || apb_wdata !== mon_wdata || apb_write !== mon_write) prot_err++;
            acc_cnt++;
        end
        apb_ready   = apb_sel && apb_en && !hang && (acc_cnt == wait_n + 1);
        prev_setup  = apb_sel && !apb_en;
        prev_access = apb_sel && apb_en;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic st, input logic [7:0] d);
        int t;
        in_valid = 1'b1;
        in_start = st;
        in_data  = d;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic get_resp(input int n, input bit toggle);
        int         t;
        logic [7:0] d0;
        for (int i = 0; i < n; i++) begin
            t = 0;
            @(negedge clk);
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("out_valid_wait", 32'(out_valid), 32'd1);
            if (!out_valid) return;
            if (toggle) begin
                d0        = out_data;
                out_ready = 1'b0;
                @(negedge clk);
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(d0));
            end
            rx_q.push_back(out_data);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        @(negedge clk);
        chk("resp_end_valid", 32'(out_valid), 32'd0);
        chk("resp_end_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic compare_resp(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() == 0) begin
                chk({tag, "_missing"}, 32'hFFFF_FFFF, 32'(e));
            end else begin
                chk(tag, 32'(rx_q.pop_front()), 32'(e));
            end
        end
        chk({tag, "_extra"}, 32'(rx_q.size()), 32'd0);
        rx_q.delete();
    endtask

    initial begin
        int n0;
        int t;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_start   = 1'b0;
        out_ready  = 1'b0;
        apb_rdata  = 32'h0;
        apb_slverr = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sel_en", {30'd0, apb_sel, apb_en}, 32'd0);
        chk("rst_write", 32'(apb_write), 32'd0);
        chk("rst_addr", apb_addr, 32'h0000_0000);
        chk("rst_wdata", apb_wdata, 32'h0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;

        // write 0x28 <= 0xA5, ready at first ACCESS cycle
        wait_n = 0;
        n0 = n_xfer;
        send_byte(1'b1, 8'h01); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h28);
        send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'hA5);
        get_resp(1, 1'b0);
        exp_q.push_back(8'h00);
        compare_resp("wr_resp");
        chk("wr_xfers", 32'(n_xfer - n0), 32'd1);
        chk("wr_dir", 32'(mon_write), 32'd1);
        chk("wr_addr", mon_addr, 32'h0000_0028);
        chk("wr_wdata", mon_wdata, 32'h0000_00A5);
        chk("wr_setup_len", 32'(setup_len), 32'd1);
        chk("wr_access_len", 32'(acc_cnt), 32'd1);

        // read 0x104, three wait states
        wait_n    = 3;
        apb_rdata = 32'h1234_5678;
        send_byte(1'b1, 8'h00); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h04);
        get_resp(5, 1'b0);
        exp_q.push_back(8'h00); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        exp_q.push_back(8'h56); exp_q.push_back(8'h78);
        compare_resp("rd_resp");
        chk("rd_dir", 32'(mon_write), 32'd0);
        chk("rd_addr", mon_addr, 32'h0000_0104);
        chk("rd_access_len", 32'(acc_cnt), 32'd4);

        // completer never ready: timeout after exactly 8 ACCESS cycles, rdata zeroed
        hang      = 1;
        apb_rdata = 32'hDEAD_BEEF;
        send_byte(1'b1, 8'h00); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h40);
        get_resp(5, 1'b0);
        exp_q.push_back(8'h02); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        compare_resp("tmo_resp");
        chk("tmo_access_len", 32'(acc_cnt), 32'd8);
        hang = 0;

        // ready on the 8th ACCESS cycle: normal completion, not a timeout
        wait_n    = 7;
        apb_rdata = 32'hA1B2_C3D4;
        send_byte(1'b1, 8'h00); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h44);
        get_resp(5, 1'b0);
        exp_q.push_back(8'h00); exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
        exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
        compare_resp("edge_resp");
        chk("edge_access_len", 32'(acc_cnt), 32'd8);

        // write with slverr, consumer stalls each byte
        wait_n     = 0;
        apb_slverr = 1'b1;
        send_byte(1'b1, 8'h01); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h30);
        send_byte(1'b0, 8'h11); send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h33);
        send_byte(1'b0, 8'h44);
        get_resp(1, 1'b1);
        exp_q.push_back(8'h01);
        compare_resp("err_resp");
        chk("err_wdata", mon_wdata, 32'h1122_3344);
        apb_slverr = 1'b0;

        // illegal command with start is dropped
        send_byte(1'b1, 8'h07);
        @(negedge clk);
        chk("illegal_state", 32'(dbg_state), 32'(ST_IDLE));

        // partial write abandoned by a new read frame
        n0        = n_xfer;
        apb_rdata = 32'hCAFE_F00D;
        send_byte(1'b1, 8'h01); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h10);
        send_byte(1'b0, 8'hAA);
        send_byte(1'b1, 8'h00); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h00);
        get_resp(5, 1'b0);
        exp_q.push_back(8'h00); exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
        exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
        compare_resp("abort_resp");
        chk("abort_xfers", 32'(n_xfer - n0), 32'd1);
        chk("abort_dir", 32'(mon_write), 32'd0);
        chk("abort_addr", mon_addr, 32'h0000_0100);

        // reset pulsed during ACCESS
        hang = 1;
        send_byte(1'b1, 8'h00); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h50);
        t = 0;
        @(negedge clk);
        while (!apb_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_reached_access", 32'(apb_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_sel_en", {30'd0, apb_sel, apb_en}, 32'd0);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        rst  = 1'b0;
        hang = 0;
        t = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) t++;
        end
        chk("rst_mid_no_resp", 32'(t), 32'd0);
        chk("rst_mid_idle", 32'(dbg_state), 32'(ST_IDLE));

        chk("apb_protocol", 32'(prot_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_apb_mst.md
I2C_APB_MST -- requirements
Module: i2c_apb_mst

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter TIMEOUT_CYC, default 256: number of ACCESS cycles with apb_ready low before the transfer is abandoned.
REQ-003 Parameter ADDR_HI, default 16'h0000: value driven on apb_addr[31:16].
REQ-004 Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request byte valid.
- in_data  in  8  request byte.
- in_start  in  1  qualifies in_valid; marks the first byte of a frame.
- in_ready  out  1  request byte accepted when in_valid & in_ready.
- out_valid  out  1  response byte valid.
- out_data  out  8  response byte.
- out_ready  in  1  response byte consumed when out_valid & out_ready.
- apb_sel  out  1  APB select.
- apb_en  out  1  APB enable.
- apb_write  out  1  APB direction; 1 = write.
- apb_addr  out  32  {ADDR_HI, frame address}.
- apb_wdata  out  32  write data.
- apb_ready  in  1  completer ready.
- apb_rdata  in  32  read data.
- apb_slverr  in  1  completer error.

Function
REQ-005 Request frame format:
- CMD byte: 8'h00 = read, 8'h01 = write.
- ADDR_H byte, then ADDR_L byte.
- Write frames only: 4 data bytes, MSB first.
REQ-006 FSM states SHALL be IDLE, ADDR, WDATA, SETUP, ACCESS, RESP, with a 3-bit byte counter.
REQ-007 IDLE:
- An accepted byte with in_start=1 and a legal CMD latches the direction and moves to ADDR.
- An accepted byte with in_start=0 or an illegal CMD is dropped; the state stays IDLE.
REQ-008 ADDR accepts 2 bytes; on the second byte it goes to SETUP for a read, or to WDATA for a write.
REQ-009 WDATA accepts 4 bytes; on the fourth byte it goes to SETUP.
REQ-010 An accepted byte with in_start=1 in ADDR or WDATA SHALL abandon the partial frame and be treated as a new CMD byte, following the IDLE rules.
REQ-011 in_ready SHALL be 1 in IDLE, ADDR and WDATA, and 0 in SETUP, ACCESS and RESP.
REQ-012 SETUP SHALL last exactly one cycle with apb_sel=1 and apb_en=0; apb_addr, apb_write and apb_wdata SHALL be stable from SETUP through the end of ACCESS.
REQ-013 ACCESS SHALL drive apb_sel=1 and apb_en=1 until apb_ready=1 is sampled.
- On that cycle apb_rdata (reads only) and apb_slverr SHALL be captured, and the state goes to RESP.
- apb_sel and apb_en SHALL be 0 in the following cycle.
REQ-014 The timeout counter SHALL count ACCESS cycles with apb_ready=0.
- On reaching TIMEOUT_CYC, the block deasserts apb_sel and apb_en, records the timeout, sets captured rdata to 32'h0, and goes to RESP.
- apb_ready=1 on the same cycle the limit is reached SHALL win: the transfer is normal, not a timeout.
REQ-015 RESP status byte SHALL be {6'b0, timeout, slverr}.
- A write response SHALL be the status byte only.
- A read response SHALL be the status byte followed by rdata MSB first (5 bytes).
REQ-016 In RESP:
- out_valid SHALL be held with out_data stable until out_ready is seen.
- The counter SHALL advance one byte per handshake.
- After the last byte the state SHALL return to IDLE; in_ready may be 1 on the next cycle.
REQ-017 Outside RESP, out_valid SHALL be 0; outside SETUP/ACCESS, apb_sel and apb_en SHALL be 0.
REQ-018 Exactly one APB transfer SHALL be outstanding at a time, and apb_en=1 SHALL never be driven without the preceding SETUP cycle.

Reset
REQ-019 While rst=1, at the next clk edge:
- The state SHALL be IDLE and the counters 0.
- apb_sel, apb_en, apb_write, out_valid SHALL be 0.
- apb_addr SHALL be {ADDR_HI,16'h0}; apb_wdata, out_data and captured status/rdata SHALL be 0.
- in_ready SHALL be 1 in the first cycle after reset.
REQ-020 Reset mid-transfer SHALL drop apb_sel/apb_en in the same edge, with no response emitted.

Structure
REQ-021 A shared package SHALL hold:
- the state enum;
- CMD_RD = 8'h00 and CMD_WR = 8'h01;
- the status bit positions;
- the response lengths (1 and 5).
REQ-022 The block SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write 01 00 28 00 00 00 A5, apb_ready=1 at first ACCESS -> APB write addr 0x00000028, data 0x000000A5; SETUP 1 cycle, ACCESS 1 cycle; response 0x00.
- Read 00 01 04, completer returns 0x12345678 after 3 wait cycles -> response 00 12 34 56 78.
- Read with apb_ready held 0, TIMEOUT_CYC=8 -> ACCESS exactly 8 cycles, then response 02 00 00 00 00.
- Write with apb_slverr=1 on the ready cycle; out_ready toggling 1/0 -> response 01, out_data held stable while out_ready=0.
- Partial write 01 00 10 AA, then new frame start 00 01 00 -> only a read of 0x00000100 is issued; no write appears on APB.
- rst pulsed during ACCESS -> apb_sel=apb_en=0 next cycle, out_valid stays 0, in_ready=1.
